// File: rtl/paddle_pkg.sv
// Shared definitions for the paddle position controller.
// Holds screen/home defaults, coordinate and delta types, and the
// update FSM state encoding.
package paddle_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int HOME_COL_DEF = 320;
  localparam int HOME_ROW_DEF = 440;

  // Unsigned screen coordinate, and the signed delta/working type that
  // can hold any difference of two coordinates without overflow.
  typedef logic [12:0]        coord_t;
  typedef logic signed [13:0] delta_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    CLAMP = 2'd2
  } state_t;

endpackage

// File: rtl/paddle_position_ctrl_if.sv
// Bus between the tracking front-end / draw stage and the paddle controller.
// Signals:
//   frame_tick, target_valid, target_row, target_col, height, width -> controller
//   crow, ccol, update_done, lost                                    <- controller
// Modports: master = the surrounding system, slave = the controller.
interface paddle_position_ctrl_if;
  import paddle_pkg::*;

  logic   frame_tick;
  logic   target_valid;
  coord_t target_row;
  coord_t target_col;
  coord_t height;
  coord_t width;
  coord_t crow;
  coord_t ccol;
  logic   update_done;
  logic   lost;

  modport master (
    output frame_tick, target_valid, target_row, target_col, height, width,
    input  crow, ccol, update_done, lost
  );

  modport slave (
    input  frame_tick, target_valid, target_row, target_col, height, width,
    output crow, ccol, update_done, lost
  );
endinterface

// File: rtl/paddle_axis_step.sv
// One axis of the paddle centre: rate-limited step toward the target,
// then clamp so the paddle of the given size stays fully on screen.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   step_en    compute the rate-limited next value (held internally)
//   clamp_en   clamp the next value and load it into centre
//   target     requested centre on this axis
//   size       paddle extent on this axis (width or height)
//   centre     registered centre, stable between clamp cycles
module paddle_axis_step
  import paddle_pkg::*;
#(
  parameter int SCREEN   = 640,
  parameter int MAX_STEP = 8,
  parameter int HOME     = 320
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   step_en,
  input  logic   clamp_en,
  input  coord_t target,
  input  coord_t size,
  output coord_t centre
);

  localparam delta_t MAX_D    = delta_t'(MAX_STEP);
  localparam delta_t SCREEN_D = delta_t'(SCREEN);
  localparam delta_t MID_D    = delta_t'(SCREEN / 2);
  localparam coord_t HOME_C   = coord_t'(HOME);

  coord_t centre_reg;
  delta_t next_reg;
  delta_t d;
  delta_t step_val;
  delta_t lo;
  delta_t hi;
  coord_t upper_half;
  delta_t clamped;

  always_comb begin
    d = delta_t'({1'b0, target}) - delta_t'({1'b0, centre_reg});
    if (d <= MAX_D && d >= -MAX_D)
      step_val = delta_t'({1'b0, target});
    else if (d > 0)
      step_val = delta_t'({1'b0, centre_reg}) + MAX_D;
    else
      step_val = delta_t'({1'b0, centre_reg}) - MAX_D;
  end

  // A zero size would make (size-1) wrap; treat its half as 0 so the
  // clamp range opens up to the full screen.
  always_comb begin
    upper_half = (size == '0) ? '0 : ((size - 13'd1) >> 1);
    lo         = delta_t'({1'b0, size >> 1});
    hi         = SCREEN_D - 14'sd1 - delta_t'({1'b0, upper_half});
    if (delta_t'({1'b0, size}) >= SCREEN_D)
      clamped = MID_D;
    else if (next_reg < lo)
      clamped = lo;
    else if (next_reg > hi)
      clamped = hi;
    else
      clamped = next_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_reg   <= delta_t'({1'b0, HOME_C});
      centre_reg <= HOME_C;
    end else begin
      if (step_en)
        next_reg <= step_val;
      if (clamp_en)
        centre_reg <= clamped[12:0];
    end
  end

  assign centre = centre_reg;

endmodule

// File: rtl/paddle_position_ctrl.sv
// Paddle position controller: latches tracking targets, moves the paddle
// centre toward the latest target once per frame (rate-limited per axis),
// clamps it on screen and falls back to the home position when the target
// has been missing for LOST_FRAMES frames.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   bus        slave side of paddle_position_ctrl_if (frame_tick, target
//              strobe/coords, paddle size in; crow/ccol, update_done, lost out)
module paddle_position_ctrl
  import paddle_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int MAX_STEP    = 8,
  parameter int LOST_FRAMES = 30,
  parameter int HOME_COL    = HOME_COL_DEF,
  parameter int HOME_ROW    = HOME_ROW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  paddle_position_ctrl_if.slave bus
);

  localparam int               CW       = $clog2(LOST_FRAMES + 1);
  localparam logic [CW-1:0]    LOST_MAX = CW'(LOST_FRAMES);
  localparam coord_t           HOME_R   = coord_t'(HOME_ROW);
  localparam coord_t           HOME_C   = coord_t'(HOME_COL);

  state_t        state_reg;
  state_t        state_next;
  logic          step_en;
  logic          clamp_en;
  logic          tick_accept;
  logic          seen_now;

  coord_t        target_row_reg;
  coord_t        target_col_reg;
  logic          seen_reg;
  logic [CW-1:0] lost_cnt_reg;
  logic          lost_reg;
  logic          update_done_reg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; ticks outside IDLE are simply dropped.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.frame_tick) state_next = STEP;
      STEP:    state_next = CLAMP;
      CLAMP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    step_en  = (state_reg == STEP);
    clamp_en = (state_reg == CLAMP);
  end

  assign tick_accept = bus.frame_tick && (state_reg == IDLE);
  // A strobe coinciding with the tick counts for the frame it starts.
  assign seen_now    = seen_reg | bus.target_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_row_reg  <= HOME_R;
      target_col_reg  <= HOME_C;
      seen_reg        <= 1'b0;
      lost_cnt_reg    <= '0;
      lost_reg        <= 1'b0;
      update_done_reg <= 1'b0;
    end else begin
      if (bus.target_valid) begin
        target_row_reg <= bus.target_row;
        target_col_reg <= bus.target_col;
        seen_reg       <= 1'b1;
      end
      if (tick_accept) begin
        if (seen_now) begin
          lost_cnt_reg <= '0;
          lost_reg     <= 1'b0;
          seen_reg     <= 1'b0;
        end else begin
          if (lost_cnt_reg != LOST_MAX)
            lost_cnt_reg <= lost_cnt_reg + 1'b1;
          // Counter hits (or already sits at) saturation: send paddle home.
          if (lost_cnt_reg >= LOST_MAX - 1'b1) begin
            lost_reg       <= 1'b1;
            target_row_reg <= HOME_R;
            target_col_reg <= HOME_C;
          end
        end
      end
      update_done_reg <= clamp_en;
    end
  end

  paddle_axis_step #(
    .SCREEN  (SCREEN_H),
    .MAX_STEP(MAX_STEP),
    .HOME    (HOME_ROW)
  ) u_row (
    .clk     (clk),
    .rst     (rst),
    .step_en (step_en),
    .clamp_en(clamp_en),
    .target  (target_row_reg),
    .size    (bus.height),
    .centre  (bus.crow)
  );

  paddle_axis_step #(
    .SCREEN  (SCREEN_W),
    .MAX_STEP(MAX_STEP),
    .HOME    (HOME_COL)
  ) u_col (
    .clk     (clk),
    .rst     (rst),
    .step_en (step_en),
    .clamp_en(clamp_en),
    .target  (target_col_reg),
    .size    (bus.width),
    .centre  (bus.ccol)
  );

  assign bus.update_done = update_done_reg;
  assign bus.lost        = lost_reg;

endmodule

// File: tb/tb_paddle_position_ctrl.sv
// Directed self-checking bench for paddle_position_ctrl.
module tb_paddle_position_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  paddle_position_ctrl_if bus();

  paddle_position_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one frame tick (optionally with a same-cycle target strobe) and
  // report how many clock edges after the tick edge update_done appeared.
  task automatic frame(input bit with_tgt, input int r, input int c, output int lat);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    if (with_tgt) begin
      bus.target_valid = 1'b1;
      bus.target_row   = 13'(r);
      bus.target_col   = 13'(c);
    end
    @(posedge clk); #1;
    bus.frame_tick   = 1'b0;
    bus.target_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus.update_done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic strobe(input int r, input int c);
    @(negedge clk);
    bus.target_valid = 1'b1;
    bus.target_row   = 13'(r);
    bus.target_col   = 13'(c);
    @(posedge clk); #1;
    bus.target_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.crow !== 13'd440 || bus.ccol !== 13'd320 || bus.update_done !== 1'b0 || bus.lost !== 1'b0) begin
      errors++;
      $display("FAIL reset: crow=%0d ccol=%0d upd=%b lost=%b, want 440 320 0 0",
               bus.crow, bus.ccol, bus.update_done, bus.lost);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("reset released: crow=%0d ccol=%0d", bus.crow, bus.ccol);
  endtask

  task automatic test_no_target();
    int lat;
    for (int i = 0; i < 3; i++) begin
      frame(1'b0, 0, 0, lat);
      checks++;
      if (lat !== 2 || bus.crow !== 13'd440 || bus.ccol !== 13'd320 || bus.lost !== 1'b0) begin
        errors++;
        $display("FAIL no_target[%0d]: lat=%0d crow=%0d ccol=%0d lost=%b, want 2 440 320 0",
                 i, lat, bus.crow, bus.ccol, bus.lost);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.update_done !== 1'b0) begin
        errors++;
        $display("FAIL no_target_pulse[%0d]: update_done=%b, want 0", i, bus.update_done);
      end
      $display("no_target frame %0d: lat=%0d ccol=%0d", i, lat, bus.ccol);
    end
  endtask

  task automatic test_track();
    int lat;
    int exp_col[3] = '{328, 330, 330};
    strobe(440, 330);
    for (int i = 0; i < 3; i++) begin
      frame(1'b0, 0, 0, lat);
      checks++;
      if (lat !== 2 || bus.ccol !== 13'(exp_col[i]) || bus.crow !== 13'd440 || bus.lost !== 1'b0) begin
        errors++;
        $display("FAIL track[%0d]: lat=%0d ccol=%0d crow=%0d lost=%b, want 2 %0d 440 0",
                 i, lat, bus.ccol, bus.crow, bus.lost, exp_col[i]);
      end
      $display("track frame %0d: ccol=%0d", i, bus.ccol);
    end
  endtask

  task automatic test_clamp();
    int lat;
    int exp;
    // Low edge: width 100 -> lo = 50.
    exp = 330;
    for (int i = 0; i < 40; i++) begin
      frame(1'b1, 440, 10, lat);
      exp = (exp - 8 < 50) ? 50 : exp - 8;
      checks++;
      if (lat !== 2 || bus.ccol !== 13'(exp)) begin
        errors++;
        $display("FAIL clamp_low[%0d]: lat=%0d ccol=%0d, want 2 %0d", i, lat, bus.ccol, exp);
      end
    end
    $display("clamp_low settled: ccol=%0d", bus.ccol);
    // High edge: width 101 -> hi = 639-50 = 589; also a target at 8191.
    bus.width = 13'd101;
    for (int i = 0; i < 72; i++) begin
      frame(1'b1, 440, (i < 40) ? 700 : 8191, lat);
      exp = (exp + 8 > 589) ? 589 : exp + 8;
      checks++;
      if (lat !== 2 || bus.ccol !== 13'(exp)) begin
        errors++;
        $display("FAIL clamp_high[%0d]: lat=%0d ccol=%0d, want 2 %0d", i, lat, bus.ccol, exp);
      end
    end
    $display("clamp_high settled: ccol=%0d", bus.ccol);
  endtask

  task automatic test_back_to_back();
    int pulses;
    @(negedge clk);
    bus.frame_tick   = 1'b1;
    bus.target_valid = 1'b1;
    bus.target_row   = 13'd440;
    bus.target_col   = 13'd500;
    @(posedge clk); #1;
    bus.target_valid = 1'b0;   // tick stays high into the STEP cycle
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.update_done) pulses++;
    end
    checks++;
    if (pulses !== 1 || bus.ccol !== 13'd581 || bus.lost !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: pulses=%0d ccol=%0d lost=%b, want 1 581 0",
               pulses, bus.ccol, bus.lost);
    end
    $display("back_to_back: pulses=%0d ccol=%0d", pulses, bus.ccol);
  endtask

  task automatic test_lost();
    int lat;
    int exp;
    for (int i = 0; i < 3; i++) frame(1'b1, 440, 700, lat);
    checks++;
    if (bus.ccol !== 13'd589) begin
      errors++;
      $display("FAIL lost_setup: ccol=%0d, want 589", bus.ccol);
    end
    for (int i = 1; i <= 30; i++) begin
      frame(1'b0, 0, 0, lat);
      checks++;
      if (i < 30) begin
        if (lat !== 2 || bus.lost !== 1'b0 || bus.ccol !== 13'd589) begin
          errors++;
          $display("FAIL lost_wait[%0d]: lat=%0d lost=%b ccol=%0d, want 2 0 589",
                   i, lat, bus.lost, bus.ccol);
        end
      end else begin
        if (lat !== 2 || bus.lost !== 1'b1 || bus.ccol !== 13'd581) begin
          errors++;
          $display("FAIL lost_hit: lat=%0d lost=%b ccol=%0d, want 2 1 581",
                   lat, bus.lost, bus.ccol);
        end
      end
    end
    $display("lost asserted: lost=%b ccol=%0d", bus.lost, bus.ccol);
    exp = 581;
    for (int i = 0; i < 3; i++) begin
      frame(1'b0, 0, 0, lat);
      exp = exp - 8;
      checks++;
      if (bus.lost !== 1'b1 || bus.ccol !== 13'(exp) || bus.crow !== 13'd440) begin
        errors++;
        $display("FAIL lost_walk[%0d]: lost=%b ccol=%0d crow=%0d, want 1 %0d 440",
                 i, bus.lost, bus.ccol, bus.crow, exp);
      end
    end
    strobe(440, 600);
    frame(1'b0, 0, 0, lat);
    checks++;
    if (bus.lost !== 1'b0 || bus.ccol !== 13'd565) begin
      errors++;
      $display("FAIL lost_clear: lost=%b ccol=%0d, want 0 565", bus.lost, bus.ccol);
    end
    $display("lost cleared: lost=%b ccol=%0d", bus.lost, bus.ccol);
  endtask

  task automatic test_reset_mid();
    int lat;
    int pulses;
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.crow !== 13'd440 || bus.ccol !== 13'd320 || bus.lost !== 1'b0 || bus.update_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: crow=%0d ccol=%0d lost=%b upd=%b, want 440 320 0 0",
               bus.crow, bus.ccol, bus.lost, bus.update_done);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.update_done) pulses++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (bus.update_done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_pulse: pulses=%0d, want 0", pulses);
    end
    frame(1'b0, 0, 0, lat);
    checks++;
    if (lat !== 2 || bus.ccol !== 13'd320 || bus.crow !== 13'd440) begin
      errors++;
      $display("FAIL reset_mid_after: lat=%0d ccol=%0d crow=%0d, want 2 320 440",
               lat, bus.ccol, bus.crow);
    end
    $display("reset_mid: ccol=%0d crow=%0d lat=%0d", bus.ccol, bus.crow, lat);
  endtask

  task automatic test_wide();
    int lat;
    bus.width = 13'd700;
    frame(1'b1, 440, 10, lat);
    checks++;
    if (bus.ccol !== 13'd320) begin
      errors++;
      $display("FAIL wide: ccol=%0d, want 320", bus.ccol);
    end
    $display("wide: ccol=%0d", bus.ccol);
    bus.width = 13'd100;
  endtask

  task automatic test_row();
    int lat;
    int exp_row[5] = '{448, 456, 464, 470, 470};
    for (int i = 0; i < 5; i++) begin
      frame(1'b1, 479, 320, lat);
      checks++;
      if (lat !== 2 || bus.crow !== 13'(exp_row[i]) || bus.ccol !== 13'd320) begin
        errors++;
        $display("FAIL row[%0d]: lat=%0d crow=%0d ccol=%0d, want 2 %0d 320",
                 i, lat, bus.crow, bus.ccol, exp_row[i]);
      end
      $display("row frame %0d: crow=%0d", i, bus.crow);
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    bus.frame_tick   = 1'b0;
    bus.target_valid = 1'b0;
    bus.target_row   = '0;
    bus.target_col   = '0;
    bus.height       = 13'd20;
    bus.width        = 13'd100;
    test_reset();
    test_no_target();
    test_track();
    test_clamp();
    test_back_to_back();
    test_lost();
    test_reset_mid();
    test_wide();
    test_row();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
